// File: rtl/twiddle_factor_lut.sv
// 64-point FFT twiddle factor ROM: W64^k = exp(-j*2*pi*k/64) in Q2.7 (1.0 = 128).
// One-cycle registered lookup; outputs decode from the registered index only.
module twiddle_factor_lut (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [5:0]        select,
  output logic signed [8:0] re_out,
  output logic signed [8:0] im_out,
  output logic              valid
);

  logic [5:0] k_reg;
  logic       loaded_reg;
  logic       valid_reg;

  // First quadrant of round(128*cos(2*pi*m/64)), m = 0..16, half away from zero.
  function automatic logic signed [8:0] quarter_cos(input logic [4:0] m);
    case (m)
      5'd0:    return 9'sd128;
      5'd1:    return 9'sd127;
      5'd2:    return 9'sd126;
      5'd3:    return 9'sd122;
      5'd4:    return 9'sd118;
      5'd5:    return 9'sd113;
      5'd6:    return 9'sd106;
      5'd7:    return 9'sd99;
      5'd8:    return 9'sd91;
      5'd9:    return 9'sd81;
      5'd10:   return 9'sd71;
      5'd11:   return 9'sd60;
      5'd12:   return 9'sd49;
      5'd13:   return 9'sd37;
      5'd14:   return 9'sd25;
      5'd15:   return 9'sd13;
      default: return 9'sd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg      <= '0;
      loaded_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= en;
      if (en) begin
        k_reg      <= select;
        loaded_reg <= 1'b1;
      end
    end
  end

  logic [4:0]        r_lo;
  logic [4:0]        r_hi;
  logic signed [8:0] cos_val;
  logic signed [8:0] sin_val;

  // Both parts come from the same k_reg, folded onto one quarter-wave table so
  // the half-circle and conjugate symmetries hold by construction.
  always_comb begin
    r_lo    = {1'b0, k_reg[3:0]};
    r_hi    = 5'd16 - r_lo;
    cos_val = '0;
    sin_val = '0;
    case (k_reg[5:4])
      2'd0: begin
        cos_val = quarter_cos(r_lo);
        sin_val = quarter_cos(r_hi);
      end
      2'd1: begin
        cos_val = -quarter_cos(r_hi);
        sin_val = quarter_cos(r_lo);
      end
      2'd2: begin
        cos_val = -quarter_cos(r_lo);
        sin_val = -quarter_cos(r_hi);
      end
      default: begin
        cos_val = quarter_cos(r_hi);
        sin_val = -quarter_cos(r_lo);
      end
    endcase
    re_out = loaded_reg ? cos_val : '0;
    im_out = loaded_reg ? -sin_val : '0;
  end

  assign valid = valid_reg;

endmodule

// File: tb/tb_twiddle_factor_lut.sv
// Self-checking bench for twiddle_factor_lut: vector table, exhaustive sweep,
// randomized stream against a trig-based model, hold and reset corner cases.
module tb_twiddle_factor_lut;

  logic              clk;
  logic              rst;
  logic              en;
  logic [5:0]        select;
  logic signed [8:0] re_out;
  logic signed [8:0] im_out;
  logic              valid;

  int checks = 0;
  int errors = 0;

  twiddle_factor_lut dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .select (select),
    .re_out (re_out),
    .im_out (im_out),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int k;
    int re;
    int im;
  } vec_t;

  vec_t vecs[7];
  int   cap_re[64];
  int   cap_im[64];

  function automatic int round_away(real v);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    return -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic int ref_re(int k);
    real pi = 3.14159265358979323846;
    return round_away(128.0 * $cos(2.0 * pi * k / 64.0));
  endfunction

  function automatic int ref_im(int k);
    real pi = 3.14159265358979323846;
    return round_away(-128.0 * $sin(2.0 * pi * k / 64.0));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [5:0] s);
    @(negedge clk);
    en     = e;
    select = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int er, input int ei, input int ev);
    check({name, " re"}, int'($signed(re_out)), er);
    check({name, " im"}, int'($signed(im_out)), ei);
    check({name, " valid"}, int'(valid), ev);
  endtask

  initial begin
    int m_k;
    int m_loaded;
    logic e;
    logic [5:0] s;

    vecs[0] = '{0, 128, 0};
    vecs[1] = '{16, 0, -128};
    vecs[2] = '{32, -128, 0};
    vecs[3] = '{48, 0, 128};
    vecs[4] = '{8, 91, -91};
    vecs[5] = '{4, 118, -49};
    vecs[6] = '{56, 91, 91};

    rst = 1'b1;
    en = 1'b0;
    select = '0;
    #1;
    check_out("reset_initial", 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: outputs stay zero until the first enabled lookup
    step(1'b0, 6'd21);
    check_out("idle_after_reset", 0, 0, 0);
    step(1'b0, 6'd40);
    check_out("idle_after_reset2", 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      step(1'b1, 6'(vecs[i].k));
      $display("vec k=%0d re=%0d im=%0d valid=%0d", vecs[i].k, re_out, im_out, valid);
      check_out($sformatf("vec_k%0d", vecs[i].k), vecs[i].re, vecs[i].im, 1);
    end
    // Raw bit encodings of the extremes
    step(1'b1, 6'd16);
    check("k16 im bits", int'(im_out[8:0]), 'h180);
    step(1'b1, 6'd0);
    check("k0 re bits", int'(re_out[8:0]), 'h080);

    // Exhaustive back-to-back sweep
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 6'(k));
      cap_re[k] = int'($signed(re_out));
      cap_im[k] = int'($signed(im_out));
      check_out($sformatf("sweep_k%0d", k), ref_re(k), ref_im(k), 1);
    end
    for (int k = 1; k < 64; k++) begin
      check($sformatf("sym_conj_re_k%0d", k), cap_re[64 - k], cap_re[k]);
      check($sformatf("sym_conj_im_k%0d", k), cap_im[64 - k], -cap_im[k]);
    end
    for (int k = 0; k < 32; k++) begin
      check($sformatf("sym_half_re_k%0d", k), cap_re[k + 32], -cap_re[k]);
      check($sformatf("sym_half_im_k%0d", k), cap_im[k + 32], -cap_im[k]);
    end

    // Randomized stream against the model
    m_k = 0;
    m_loaded = 1;
    step(1'b1, 6'd0);
    for (int i = 0; i < 200; i++) begin
      e = 1'($urandom_range(0, 1));
      s = 6'($urandom_range(0, 63));
      step(e, s);
      if (e) m_k = int'(s);
      check_out($sformatf("rand_%0d", i), m_loaded ? ref_re(m_k) : 0,
                m_loaded ? ref_im(m_k) : 0, int'(e));
    end

    // Hold: load k=8, then disable with select wiggling, including between edges
    step(1'b1, 6'd8);
    check_out("hold_load", 91, -91, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'($urandom_range(0, 63)));
      #1 select = 6'($urandom_range(0, 63));
      #1;
      check_out($sformatf("hold_%0d", i), 91, -91, 0);
    end

    // Asynchronous reset mid-cycle, no clock edge in between
    step(1'b1, 6'd32);
    check_out("pre_async", -128, 0, 1);
    #2 rst = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-stream reset during a sweep
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 6'(k + 20));
      check_out($sformatf("stream_k%0d", k + 20), ref_re(k + 20), ref_im(k + 20), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    select = 6'd30;
    @(posedge clk);
    #1;
    check_out("midstream_reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 0, 0, 0);
    step(1'b1, 6'd12);
    check_out("post_reset_k12", 49, -118, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
